// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check
// Receive-path FCS and length checker. It consumes the frame-byte stream
// (DA through FCS, preamble/SFD already stripped) and runs reflected CRC-32
// over every byte, FCS included. One cycle after the frame ends it pulses
// o_done and updates the held verdict (CRC ok/err, runt, giant, rx error
// seen, length). It also keeps saturating good/bad frame counters. No data
// passes through this block.
module eth_rx_fcs_check #(
  parameter int pMAX_LEN = 1518,
  parameter int pMIN_LEN = 64,
  parameter int pCNT_W   = 16
) (
  input  logic              i_rx_clk,
  input  logic              i_rst,
  input  logic              i_rx_dv,
  input  logic              i_rx_er,
  input  logic [7:0]        i_rx_d,
  output logic              o_done,
  output logic              o_crc_ok,
  output logic              o_crc_err,
  output logic              o_runt,
  output logic              o_giant,
  output logic              o_er_seen,
  output logic [10:0]       o_len,
  output logic [pCNT_W-1:0] o_good_cnt,
  output logic [pCNT_W-1:0] o_bad_cnt
);

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [pCNT_W-1:0] CNT_ONE = {{(pCNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] crc_q;
  logic [10:0] len_q;
  logic        er_q;

  // One byte of LSB-first reflected CRC-32; the register is not inverted.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data);
    logic [31:0] r;
    // NOTE: blocking assignments are correct here; r is a local temporary
    // rebuilt bit by bit, not a register.
    r = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ data[i]) r = (r >> 1) ^ CRC_POLY;
      else                r = r >> 1;
    end
    return r;
  endfunction

  // End-of-frame verdict, evaluated from the accumulated state.
  logic [31:0] len_ext;
  logic        v_crc_ok;
  logic        v_runt;
  logic        v_giant;
  logic        v_good;

  always_comb begin
    len_ext  = {21'd0, len_q};
    v_crc_ok = (crc_q == CRC_RESIDUE) && (len_q >= 11'd4) && !er_q;
    v_runt   = len_ext < 32'(pMIN_LEN);
    v_giant  = len_ext > 32'(pMAX_LEN);
    v_good   = v_crc_ok && !v_runt && !v_giant;
  end

  // Frame FSM with registered verdict outputs and saturating counters.
  // NOTE: every register below uses non-blocking assignment so all of them
  // update together on the edge, independent of statement order.
  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      crc_q      <= CRC_INIT;
      len_q      <= '0;
      er_q       <= 1'b0;
      o_done     <= 1'b0;
      o_crc_ok   <= 1'b0;
      o_crc_err  <= 1'b0;
      o_runt     <= 1'b0;
      o_giant    <= 1'b0;
      o_er_seen  <= 1'b0;
      o_len      <= '0;
      o_good_cnt <= '0;
      o_bad_cnt  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_rx_dv) begin
            // The first byte is absorbed with a fresh CRC seed.
            crc_q <= crc_byte(CRC_INIT, i_rx_d);
            len_q <= 11'd1;
            er_q  <= i_rx_er;
            state <= S_RECV;
          end
        end
        S_RECV: begin
          if (i_rx_dv) begin
            crc_q <= crc_byte(crc_q, i_rx_d);
            if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
            er_q  <= er_q | i_rx_er;
          end else begin
            o_done    <= 1'b1;
            o_crc_ok  <= v_crc_ok;
            o_crc_err <= !v_crc_ok;
            o_runt    <= v_runt;
            o_giant   <= v_giant;
            o_er_seen <= er_q;
            o_len     <= len_q;
            if (v_good) begin
              if (o_good_cnt != '1) o_good_cnt <= o_good_cnt + CNT_ONE;
            end else begin
              if (o_bad_cnt != '1) o_bad_cnt <= o_bad_cnt + CNT_ONE;
            end
            crc_q <= CRC_INIT;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
